// File: rtl/multicycle_microprocessor_if.sv
// Instruction-fetch handshake between the processor (master) and an external
// instruction memory (slave): request/address out, valid/instruction word back.
interface multicycle_microprocessor_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               req;
    logic [PC_W-1:0]    addr;
    logic               valid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input valid, input rdata);
    modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/multicycle_microprocessor.sv
// Parametrised multi-cycle processor: FETCH/DECODE/EXEC/MEM/WB/HALT with internal data memory.
// Optional macro SINGLE_STEP_EN adds a step input that gates instruction fetch.
module multicycle_microprocessor #(
    parameter int DATA_W            = 8,
    parameter int REG_ADDR_W        = 2,
    parameter int PC_W              = 8,
    parameter int LOWER_DMEM_LIMIT  = 0,
    parameter int HIGHER_DMEM_LIMIT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef SINGLE_STEP_EN
    input  logic                       step,
`endif
    multicycle_microprocessor_if.master imem,
    output logic [PC_W-1:0]            pc,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       wb_valid,
    output logic [2:0]                 flags
);
    localparam int INSTR_W    = 2 + 3 * REG_ADDR_W;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int DMEM_DEPTH = HIGHER_DMEM_LIMIT - LOWER_DMEM_LIMIT + 1;
    localparam int DMEM_AW    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_MEM  = 2'b10;
    localparam logic [1:0] OP_BR   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t                  state_reg, state_next;
    logic [INSTR_W-1:0]      ir_reg;
    logic [DATA_W-1:0]       op_a_reg, op_b_reg;
    logic [PC_W-1:0]         pc_reg;
    logic [DATA_W-1:0]       wb_data_reg;
    logic                    wb_valid_reg;
    logic [2:0]              flags_reg;
    logic [DATA_W-1:0]       rf [NUM_REGS];
    logic [DATA_W-1:0]       dmem [DMEM_DEPTH];

    logic                    req_c, rf_we_c;
    logic [1:0]              op;
    logic [REG_ADDR_W-1:0]   rs, rt, rd;
    logic [DATA_W-1:0]       imm_data, alu_b, alu_sum, load_data;
    logic [PC_W-1:0]         imm_pc, br_target;
    logic                    alu_ovf, br_halt, is_store, fetch_fire, addr_in_range;
    logic [REG_ADDR_W-1:0]   rf_waddr;
    logic [DMEM_AW-1:0]      dmem_idx;

    assign op = ir_reg[INSTR_W-1 -: 2];
    assign rs = ir_reg[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rt = ir_reg[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rd = ir_reg[REG_ADDR_W-1:0];

    assign imm_data = {{(DATA_W-REG_ADDR_W){rd[REG_ADDR_W-1]}}, rd};
    assign imm_pc   = {{(PC_W-REG_ADDR_W){rd[REG_ADDR_W-1]}}, rd};
    assign is_store = rd[0];
    assign br_halt  = &rd;

`ifdef SINGLE_STEP_EN
    assign fetch_fire = imem.valid && step;
`else
    assign fetch_fire = imem.valid;
`endif

    assign alu_b     = (op == OP_ADDI) ? imm_data : op_b_reg;
    assign alu_sum   = op_a_reg + alu_b;
    // Signed overflow: operands agree in sign but the sum does not.
    assign alu_ovf   = (op_a_reg[DATA_W-1] == alu_b[DATA_W-1]) &&
                       (alu_sum[DATA_W-1] != op_a_reg[DATA_W-1]);
    assign br_target = pc_reg + PC_W'(1) + imm_pc;

    generate
        if (LOWER_DMEM_LIMIT == 0) begin : g_range_from_zero
            assign addr_in_range = (op_a_reg <= DATA_W'(HIGHER_DMEM_LIMIT));
        end else begin : g_range_window
            assign addr_in_range = (op_a_reg >= DATA_W'(LOWER_DMEM_LIMIT)) &&
                                   (op_a_reg <= DATA_W'(HIGHER_DMEM_LIMIT));
        end
    endgenerate

    assign dmem_idx  = DMEM_AW'(op_a_reg - DATA_W'(LOWER_DMEM_LIMIT));
    assign load_data = addr_in_range ? dmem[dmem_idx] : '0;
    assign rf_waddr  = (op == OP_ADD) ? rd : rt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (fetch_fire) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_MEM:  state_next = S_MEM;
                    OP_BR:   state_next = br_halt ? S_HALT : S_FETCH;
                    default: state_next = S_WB;
                endcase
            end
            S_MEM:    state_next = is_store ? S_FETCH : S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Request is gated by reset so it drops the instant reset asserts.
    always_comb begin
        req_c   = 1'b0;
        rf_we_c = 1'b0;
        if (state_reg == S_FETCH) req_c = reset;
        if (state_reg == S_WB)    rf_we_c = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_reg       <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            pc_reg       <= '0;
            wb_data_reg  <= '0;
            wb_valid_reg <= 1'b0;
            flags_reg    <= '0;
        end else begin
            wb_valid_reg <= (state_next == S_WB);
            case (state_reg)
                S_FETCH:  if (fetch_fire) ir_reg <= imem.rdata;
                S_DECODE: begin
                    op_a_reg <= rf[rs];
                    op_b_reg <= rf[rt];
                end
                S_EXEC: begin
                    case (op)
                        OP_BR: begin
                            if (br_halt) flags_reg[0] <= 1'b1;
                            else         pc_reg <= br_target;
                        end
                        OP_MEM: pc_reg <= pc_reg + PC_W'(1);
                        default: begin
                            pc_reg      <= pc_reg + PC_W'(1);
                            wb_data_reg <= alu_sum;
                            if (alu_ovf) flags_reg[1] <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (!addr_in_range) flags_reg[2] <= 1'b1;
                    if (!is_store)      wb_data_reg <= load_data;
                end
                default: ;
            endcase
        end
    end

    // Register file and data memory must clear on reset, so each word is a flop.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    word_reg <= '0;
                else if (rf_we_c && (rf_waddr == REG_ADDR_W'(gi)))
                    word_reg <= wb_data_reg;
            end
            assign rf[gi] = word_reg;
        end

        for (genvar gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    word_reg <= '0;
                else if ((state_reg == S_MEM) && is_store && addr_in_range &&
                         (dmem_idx == DMEM_AW'(gi)))
                    word_reg <= op_b_reg;
            end
            assign dmem[gi] = word_reg;
        end
    endgenerate

    assign imem.req  = req_c;
    assign imem.addr = pc_reg;
    assign pc        = pc_reg;
    assign wb_data   = wb_data_reg;
    assign wb_valid  = wb_valid_reg;
    assign flags     = flags_reg;
endmodule
